// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  // Controller states: waiting for operands, shifting bits through the FA cell,
  // and holding a finished result for the consumer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width. It must be at least one bit, because W=1 still needs a
  // counter that can hold 0.
  function automatic int cnt_width(input int w);
    if (w <= 1) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder, built from two half-adder stages and an OR.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  // Stage 1 adds a+b. Stage 2 adds the partial sum and cin. The two stages can
  // never both produce a carry, so an OR merges them.
  always_comb begin
    s1   = a ^ b;
    c1   = a & b;
    s    = s1 ^ cin;
    c2   = s1 & cin;
    cout = c1 | c2;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. It adds two W-bit operands LSB-first through one
// full-adder cell and takes W cycles per result.
// Optional feature: define SERIAL_ADD_SUB_EN to add the in_sub port, which
// turns on subtraction (A - B).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds its data while valid is high and ready is low. The
// block holds out_valid, out_sum and out_cout stable until out_ready is sampled
// high.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy,
  output state_t       dbg_state
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   sum_sh;
  logic [W-1:0]   sum_q;
  logic           carry;
  logic           cout_q;
  logic           sub_q;
  logic [CW-1:0]  count;

  logic           sub_in;
  logic           fa_b;
  logic           fa_s;
  logic           fa_c;
  logic [W-1:0]   sum_next;

  // Select the operation mode for the incoming operands. It is fixed at add
  // when subtraction is not built in.
`ifdef SERIAL_ADD_SUB_EN
  always_comb sub_in = in_sub;
`else
  always_comb sub_in = 1'b0;
`endif

  // Form the FA cell's B input. In subtract mode B is inverted, and the carry
  // preload supplies the +1 of the two's complement. The new sum bit enters the
  // sum register at the MSB side.
  always_comb begin
    fa_b     = b_sh[0] ^ sub_q;
    sum_next = (sum_sh >> 1) | (W'(fa_s) << (W - 1));
  end

  serial_fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Controller: accept operands in IDLE, do one bit per cycle in RUN, and hold
  // the result in DONE. sum_q and cout_q change only when a result completes.
  // This keeps the outputs stable after DONE until the next result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      sub_q  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            sub_q <= sub_in;
            carry <= in_cin ^ sub_in;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_c;
          count  <= count + CW'(1);
          if (count == LAST) begin
            sum_q  <= sum_next;
            cout_q <= fa_c;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drive the outputs and handshake signals from the state and the result
  // registers.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_sum   = sum_q;
    out_cout  = cout_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with W=4.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
  state_t       dbg_state;

  serial_add_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  // Call at a negedge. Presents one operand set, measures the accept-to-valid
  // latency, stalls the consumer for `stall` cycles, then completes the output
  // handshake.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input int stall,
                       input logic [W-1:0] es, input logic ec);
    int lat;
    logic [W:0] exp_r;
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    in_sub = sub;
`else
    if (sub) $display("note: %s requests subtract in an add-only build", nm);
`endif
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back({ec, es});
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * W + 4) begin
      check({nm, "_busy_run"}, 32'(busy), 32'd1);
      check({nm, "_rdy_run"}, 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(W));
    exp_r = exp_q.pop_front();
    if (!out_valid) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < stall; k++) begin
      check({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_stall_sum"}, 32'(out_sum), 32'(exp_r[W-1:0]));
      check({nm, "_stall_cout"}, 32'(out_cout), 32'(exp_r[W]));
      check({nm, "_stall_rdy"}, 32'(in_ready), 32'd0);
      step();
    end
    check({nm, "_sum"}, 32'(out_sum), 32'(exp_r[W-1:0]));
    check({nm, "_cout"}, 32'(out_cout), 32'(exp_r[W]));
    check({nm, "_busy_done"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({nm, "_sum_kept"}, 32'(out_sum), 32'(exp_r[W-1:0]));
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           stall;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  int acc_cyc[2];
  int n_acc;
  int n_res;
  logic [W:0] exp_r;

  initial begin
    vecs[0] = '{a: 4'hF, b: 4'h1, cin: 1'b0, stall: 0, sum: 4'h0, cout: 1'b1};
    vecs[1] = '{a: 4'h0, b: 4'h0, cin: 1'b1, stall: 0, sum: 4'h1, cout: 1'b0};
    vecs[2] = '{a: 4'h9, b: 4'h7, cin: 1'b1, stall: 5, sum: 4'h1, cout: 1'b1};
    vecs[3] = '{a: 4'h5, b: 4'hA, cin: 1'b0, stall: 1, sum: 4'hF, cout: 1'b0};
    vecs[4] = '{a: 4'hF, b: 4'hF, cin: 1'b1, stall: 0, sum: 4'hF, cout: 1'b1};
    vecs[5] = '{a: 4'h8, b: 4'h8, cin: 1'b0, stall: 2, sum: 4'h0, cout: 1'b1};
    vecs[6] = '{a: 4'h6, b: 4'h3, cin: 1'b1, stall: 0, sum: 4'hA, cout: 1'b0};
    vecs[7] = '{a: 4'hA, b: 4'h5, cin: 1'b1, stall: 0, sum: 4'h0, cout: 1'b1};

    // Reset: hold for a few cycles, then check the reset values.
    rst = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step();

    // Table-driven operations.
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
            vecs[i].stall, vecs[i].sum, vecs[i].cout);
    end

    // Reset two cycles after accept: the operation is aborted.
    in_a = 4'h6; in_b = 4'h6; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(out_sum), 32'd0);
    check("abort_cout", 32'(out_cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(in_ready), 32'd1);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    do_op("after_abort", 4'h3, 4'h4, 1'b0, 1'b0, 0, 4'h7, 1'b0);

    // Back-to-back: in_valid and out_ready both held high.
    in_a = 4'h1; in_b = 4'h2; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    for (int k = 0; k < 40 && (n_acc < 2 || n_res < 2); k++) begin
      if (in_valid && in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        exp_q.push_back(n_acc == 1 ? {1'b0, 4'h3} : {1'b1, 4'h2});
      end
      if (out_valid && out_ready) begin
        exp_r = exp_q.pop_front();
        check($sformatf("b2b_sum%0d", n_res), 32'(out_sum), 32'(exp_r[W-1:0]));
        check($sformatf("b2b_cout%0d", n_res), 32'(out_cout), 32'(exp_r[W]));
        n_res++;
      end
      step();
      if (n_acc == 1) begin
        in_a = 4'hC; in_b = 4'h5; in_cin = 1'b1;
      end
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_results", 32'(n_res), 32'd2);
    if (n_acc == 2) check("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
    step();

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction: 5-7 borrows, and 7-5 does not.
    do_op("sub_5m7", 4'h5, 4'h7, 1'b0, 1'b1, 0, 4'hE, 1'b0);
    do_op("sub_7m5", 4'h7, 4'h5, 1'b0, 1'b1, 0, 4'h2, 1'b1);
    in_sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
